// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits.
// The received word is held under a valid/ready handshake and reports frame, parity, break and overrun.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 20,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Rx_Ready,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF      = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    state_t               state;
    logic                 sync_1;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 data_xor;
    logic                 par_err;
    logic                 stop_bad;
    logic                 any_one;

    logic bit_tick;
    logic frame_done;
    logic new_frame_err;
    logic new_break;
    logic load;

    // Frame completes on the last stop sample; it is kept only if the holding register is free.
    assign bit_tick      = (cnt == FULL);
    assign frame_done    = (state == S_STOP) && bit_tick && (bit_idx == LAST_STOP);
    assign new_frame_err = stop_bad | ~rx_s;
    assign new_break     = ~any_one & ~rx_s;
    assign load          = frame_done && (!o_Rx_DV || i_Rx_Ready);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync_1       <= 1'b1;
            rx_s         <= 1'b1;
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            data_xor     <= 1'b0;
            par_err      <= 1'b0;
            stop_bad     <= 1'b0;
            any_one      <= 1'b0;
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
            o_Overrun    <= 1'b0;
        end else begin
            sync_1 <= i_Rx_Serial;
            rx_s   <= sync_1;

            case (state)
                S_IDLE: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    data_xor <= 1'b0;
                    par_err  <= 1'b0;
                    stop_bad <= 1'b0;
                    any_one  <= 1'b0;
                    if (!rx_s) state <= S_START;
                end
                // A start bit that is high again at mid-bit is treated as a glitch.
                S_START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        cnt       <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        data_xor  <= data_xor ^ rx_s;
                        any_one   <= any_one | rx_s;
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        any_one <= any_one | rx_s;
                        par_err <= (PARITY == 1) ? ~(data_xor ^ rx_s) : (data_xor ^ rx_s);
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        cnt      <= '0;
                        stop_bad <= stop_bad | ~rx_s;
                        any_one  <= any_one | rx_s;
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            state   <= new_break ? S_BREAK_WAIT : S_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK_WAIT: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (load) begin
                o_Rx_DV      <= 1'b1;
                o_Rx_Byte    <= shift_reg;
                o_Parity_Err <= par_err;
                o_Frame_Err  <= new_frame_err;
                o_Break      <= new_break;
                o_Overrun    <= 1'b0;
            end else if (frame_done) begin
                o_Overrun <= 1'b1;
            end else if (o_Rx_DV && i_Rx_Ready) begin
                o_Rx_DV   <= 1'b0;
                o_Overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: three configurations driven in turn, words checked
// against a queue of expected results as each is accepted.
module tb_uart_rx_frame;

    localparam int CPB_A = 20;
    localparam int CPB_B = 8;
    localparam int CPB_C = 8;

    typedef struct {
        int         which;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       rx_a = 1'b1, ready_a = 1'b0;
    logic       dv_a, perr_a, ferr_a, brk_a, ovr_a;
    logic [7:0] byte_a;

    logic       rx_b = 1'b1, ready_b = 1'b1;
    logic       dv_b, perr_b, ferr_b, brk_b, ovr_b;
    logic [6:0] byte_b;

    logic       rx_c = 1'b1, ready_c = 1'b1;
    logic       dv_c, perr_c, ferr_c, brk_c, ovr_c;
    logic [7:0] byte_c;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   word_cnt[3] = '{0, 0, 0};
    int   exp_cnt[3] = '{0, 0, 0};
    int   dv_hi_a = 0;
    int   rise_a = -1;
    logic dv_a_prev = 1'b0;

    uart_rx_frame #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a), .i_Rx_Ready(ready_a),
        .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a), .o_Parity_Err(perr_a),
        .o_Frame_Err(ferr_a), .o_Break(brk_a), .o_Overrun(ovr_a)
    );

    uart_rx_frame #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(7), .PARITY(2)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b), .i_Rx_Ready(ready_b),
        .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b), .o_Parity_Err(perr_b),
        .o_Frame_Err(ferr_b), .o_Break(brk_b), .o_Overrun(ovr_b)
    );

    uart_rx_frame #(.CLKS_PER_BIT(CPB_C), .PARITY(1), .STOP_BITS(2)) dut_c (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_c), .i_Rx_Ready(ready_c),
        .o_Rx_DV(dv_c), .o_Rx_Byte(byte_c), .o_Parity_Err(perr_c),
        .o_Frame_Err(ferr_c), .o_Break(brk_c), .o_Overrun(ovr_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_word(input int which, input logic [8:0] data, input logic perr,
                              input logic ferr, input logic brk);
        exp_t e;
        word_cnt[which]++;
        checkOutput("word_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("word_source", which, e.which);
            checkOutput("word_data", 32'(data), 32'(e.data));
            checkOutput("word_parity_err", 32'(perr), 32'(e.perr));
            checkOutput("word_frame_err", 32'(ferr), 32'(e.ferr));
            checkOutput("word_break", 32'(brk), 32'(e.brk));
        end
    endtask

    // Words are checked at the moment the consumer takes them.
    always @(negedge clk) begin
        if (!rst) begin
            if (dv_a) dv_hi_a++;
            if (dv_a && !dv_a_prev) rise_a = cyc;
            if (dv_a && ready_a) check_word(0, {1'b0, byte_a}, perr_a, ferr_a, brk_a);
            if (dv_b && ready_b) check_word(1, {2'b0, byte_b}, perr_b, ferr_b, brk_b);
            if (dv_c && ready_c) check_word(2, {1'b0, byte_c}, perr_c, ferr_c, brk_c);
        end
        dv_a_prev = dv_a;
    end

    function automatic logic [15:0] frame_bits(input logic [8:0] data, input int dbits,
                                               input int par_mode, input logic par_flip,
                                               input int stops, input logic last_stop);
        logic [15:0] f;
        int          pos;
        logic        p;
        f   = '1;
        f[0] = 1'b0;
        pos = 1;
        p   = 1'b0;
        for (int i = 0; i < dbits; i++) begin
            f[pos] = data[i];
            p      = p ^ data[i];
            pos++;
        end
        if (par_mode != 0) begin
            f[pos] = ((par_mode == 1) ? ~p : p) ^ par_flip;
            pos++;
        end
        for (int i = 0; i < stops; i++) begin
            f[pos] = (i == stops - 1) ? last_stop : 1'b1;
            pos++;
        end
        return f;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        case (which)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic applyStimulus(input int which, input logic [15:0] bits, input int nbits);
        int cpb;
        cpb = (which == 0) ? CPB_A : ((which == 1) ? CPB_B : CPB_C);
        for (int i = 0; i < nbits; i++) begin
            set_line(which, bits[i]);
            repeat (cpb) @(posedge clk);
            #1;
        end
        set_line(which, 1'b1);
    endtask

    task automatic expect_word(input int which, input logic [8:0] data, input logic perr,
                               input logic ferr, input logic brk);
        exp_t e;
        e.which = which;
        e.data  = data;
        e.perr  = perr;
        e.ferr  = ferr;
        e.brk   = brk;
        sb.push_back(e);
        exp_cnt[which]++;
    endtask

    task automatic wait_words(input int which);
        for (int i = 0; i < 800 && word_cnt[which] < exp_cnt[which]; i++) idle(1);
        checkOutput("words_received", word_cnt[which], exp_cnt[which]);
    endtask

    task automatic check_a_cleared(input string tag);
        checkOutput({tag, "_dv"}, 32'(dv_a), 32'd0);
        checkOutput({tag, "_byte"}, 32'(byte_a), 32'd0);
        checkOutput({tag, "_flags"}, 32'({perr_a, ferr_a, brk_a, ovr_a}), 32'd0);
    endtask

    initial begin
        int k;
        int words_before;

        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;

        $display("[TB] reset state");
        check_a_cleared("reset_a");
        checkOutput("reset_b_dv", 32'(dv_b), 32'd0);
        checkOutput("reset_c_dv", 32'(dv_c), 32'd0);
        idle(4);

        $display("[TB] 8N1 0xA5 latency and one-cycle valid");
        dv_hi_a = 0;
        k = cyc + 1;
        expect_word(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, frame_bits(9'h0A5, 8, 0, 1'b0, 1, 1'b1), 10);
        wait_words(0);
        idle(20);
        checkOutput("a5_rise_cycle", rise_a, k + 192);
        checkOutput("a5_dv_cycles", dv_hi_a, 1);

        $display("[TB] 7E1 parity");
        expect_word(1, 9'h035, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, frame_bits(9'h035, 7, 2, 1'b0, 1, 1'b1), 10);
        expect_word(1, 9'h035, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, frame_bits(9'h035, 7, 2, 1'b1, 1, 1'b1), 10);
        expect_word(1, 9'h07F, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, frame_bits(9'h07F, 7, 2, 1'b0, 1, 1'b1), 10);
        wait_words(1);

        $display("[TB] 8O2 stop bits and odd parity");
        expect_word(2, 9'h0C3, 1'b0, 1'b1, 1'b0);
        applyStimulus(2, frame_bits(9'h0C3, 8, 1, 1'b0, 2, 1'b0), 12);
        idle(2);
        expect_word(2, 9'h03C, 1'b0, 1'b0, 1'b0);
        applyStimulus(2, frame_bits(9'h03C, 8, 1, 1'b0, 2, 1'b1), 12);
        expect_word(2, 9'h081, 1'b1, 1'b0, 1'b0);
        applyStimulus(2, frame_bits(9'h081, 8, 1, 1'b1, 2, 1'b1), 12);
        wait_words(2);

        $display("[TB] break");
        words_before = word_cnt[0];
        expect_word(0, 9'h000, 1'b0, 1'b1, 1'b1);
        set_line(0, 1'b0);
        idle(12 * CPB_A);
        checkOutput("break_words_while_low", word_cnt[0], words_before + 1);
        set_line(0, 1'b1);
        idle(3 * CPB_A);
        checkOutput("break_words_after_release", word_cnt[0], words_before + 1);
        expect_word(0, 9'h012, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, frame_bits(9'h012, 8, 0, 1'b0, 1, 1'b1), 10);
        wait_words(0);

        $display("[TB] overrun");
        ready_a = 1'b0;
        expect_word(0, 9'h011, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, frame_bits(9'h011, 8, 0, 1'b0, 1, 1'b1), 10);
        applyStimulus(0, frame_bits(9'h022, 8, 0, 1'b0, 1, 1'b1), 10);
        idle(2);
        checkOutput("ovr_held_dv", 32'(dv_a), 32'd1);
        checkOutput("ovr_held_byte", 32'(byte_a), 32'h11);
        checkOutput("ovr_flag", 32'(ovr_a), 32'd1);
        ready_a = 1'b1;
        idle(1);
        ready_a = 1'b0;
        checkOutput("ovr_after_accept_dv", 32'(dv_a), 32'd0);
        checkOutput("ovr_after_accept_flag", 32'(ovr_a), 32'd0);
        ready_a = 1'b1;
        expect_word(0, 9'h033, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, frame_bits(9'h033, 8, 0, 1'b0, 1, 1'b1), 10);
        wait_words(0);

        $display("[TB] start glitch");
        words_before = word_cnt[0];
        set_line(0, 1'b0);
        idle((CPB_A - 1) / 2 - 1);
        set_line(0, 1'b1);
        idle(3 * CPB_A);
        checkOutput("glitch_no_word", word_cnt[0], words_before);
        checkOutput("glitch_dv", 32'(dv_a), 32'd0);

        $display("[TB] reset mid-frame");
        ready_a = 1'b0;
        expect_word(0, 9'h077, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, frame_bits(9'h077, 8, 0, 1'b0, 1, 1'b1), 10);
        applyStimulus(0, frame_bits(9'h066, 8, 0, 1'b0, 1, 1'b1), 10);
        idle(2);
        checkOutput("pre_reset_ovr", 32'(ovr_a), 32'd1);
        set_line(0, 1'b0);
        idle(CPB_A);
        set_line(0, 1'b1);
        idle(2 * CPB_A);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_a_cleared("midreset_a");
        sb.delete();
        exp_cnt[0]--;
        ready_a = 1'b1;
        idle(5);
        expect_word(0, 9'h05A, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, frame_bits(9'h05A, 8, 0, 1'b0, 1, 1'b1), 10);
        wait_words(0);

        idle(10);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver for 5–9 data bits, optional odd/even parity and 1 or 2 stop bits, with per-frame error flags and break detection. Sits between the pad-side serial input and the byte-consuming logic. Replaces the fixed 8N1 receiver. Received words are held in a one-entry output register under a valid/ready handshake, so a slow consumer causes a reported overrun instead of silent loss.

## Interface
- CLKS_PER_BIT, 20: clock cycles per bit; legal values are 4 and above.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- i_Clock  in  1  sole clock; all logic on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_Serial  in  1  asynchronous serial line, idle high.
- i_Rx_Ready  in  1  consumer accepts the held word when high with o_Rx_DV.
- o_Rx_DV  out  1  held word valid; reset value 0.
- o_Rx_Byte  out  DATA_BITS  received data, LSB first on the wire; reset value 0.
- o_Parity_Err  out  1  parity mismatch in the held word; reset value 0; meaningful only while o_Rx_DV is high.
- o_Frame_Err  out  1  one or more stop samples were 0; reset value 0; meaningful only while o_Rx_DV is high.
- o_Break  out  1  held word is a break; reset value 0; meaningful only while o_Rx_DV is high.
- o_Overrun  out  1  sticky; a completed frame was dropped; reset value 0.

## Operation
- **Synchroniser.** Two-flop synchroniser on i_Rx_Serial; both flops reset to 1. The FSM sees only the second flop (`rx_s`).
- **Timing constants.** Bit counter width is $clog2(CLKS_PER_BIT). Half-bit point H = (CLKS_PER_BIT-1)/2, using integer division.
- **IDLE.**
  - Clear the counter and bit index.
  - If rx_s = 0, go to START.
- **START.**
  - Increment the counter until it equals H, then sample rx_s.
  - Sample 0: clear the counter and go to DATA.
  - Sample 1: glitch. Return to IDLE and produce no output.
- **DATA.**
  - Sample when counter = CLKS_PER_BIT-1, then clear the counter.
  - Shift samples LSB first into a DATA_BITS shift register and accumulate their XOR.
  - After DATA_BITS samples, go to PARITY if PARITY ≠ 0, otherwise to STOP.
- **PARITY.**
  - Sample once at the same spacing as DATA.
  - Error if data-XOR ^ parity-bit ≠ 1 (odd) or ≠ 0 (even).
- **STOP.**
  - Sample STOP_BITS times at the same spacing. Frame error if any sample is 0.
  - After the final stop sample, go to BREAK_WAIT if the frame is a break, otherwise go to IDLE directly. There is no full-bit wait and no cleanup state, so back-to-back frames are received.
- **Break definition.** All data samples, the parity sample (if present) and every stop sample are 0.
- **BREAK_WAIT.** Stay until rx_s = 1, then go to IDLE.
- **Frame completion.** Happens in the cycle of the final stop sample.
  - If the held word is empty (o_Rx_DV = 0), or is being accepted this cycle (o_Rx_DV & i_Rx_Ready), load o_Rx_Byte, o_Parity_Err, o_Frame_Err and o_Break, and set o_Rx_DV = 1.
  - Otherwise drop the new frame, leave the held word unchanged and set o_Overrun.
- **Handshake.**
  - o_Rx_DV & i_Rx_Ready with no simultaneous load clears o_Rx_DV and o_Overrun.
  - Outputs stay stable while o_Rx_DV = 1 and i_Rx_Ready = 0.
- **Simultaneous accept and load.** The new word replaces the old, o_Rx_DV stays 1 and o_Overrun is cleared.
- **Reset.** i_Reset at any point, including mid-frame:
  - FSM goes to IDLE.
  - Synchroniser flops go to 1.
  - All outputs go to their reset values.
  - Any partial frame is discarded.

## Timing
- Let edge k be the first rising edge at which i_Rx_Serial is low at the start bit.
  - IDLE sees rx_s = 0 at edge k+2.
  - Mid-start sample at edge k+H+3.
  - Bit j (j = 0 for the first data bit, counting through parity and stop bits) is sampled at edge k+H+3+(j+1)·CLKS_PER_BIT.
- o_Rx_DV rises after the final sample edge: k+H+3+N·CLKS_PER_BIT, where N = DATA_BITS + (PARITY≠0) + STOP_BITS.
  - Example: defaults (8N1, CPB = 20, H = 9) give k+192.
- o_Rx_DV falls one cycle after the accepting edge.
- o_Overrun rises in the cycle after the dropped frame's final sample.
- Start-bit detect latency is 3 cycles; the next frame's start edge is detected immediately after the final stop sample.

## Test plan
- **Default 8N1, byte 0xA5, i_Rx_Ready = 1.** o_Rx_DV is high for exactly 1 cycle at k+192; o_Rx_Byte = 0xA5; all error flags are 0.
- **PARITY = 2, DATA_BITS = 7.**
  - 0x35 with correct parity bit 0: o_Parity_Err = 0.
  - Same frame with the parity bit flipped: o_Parity_Err = 1, o_Rx_Byte = 0x35.
- **STOP_BITS = 2, second stop driven low.** o_Frame_Err = 1, o_Break = 0, data correct.
- **Line held low for 12 bit times, then released.**
  - Exactly one word: o_Rx_Byte = 0, o_Frame_Err = 1, o_Break = 1.
  - No second frame is received until after the line goes high.
- **i_Rx_Ready = 0, frames 0x11 then 0x22 sent back-to-back.**
  - The held word stays 0x11 and o_Overrun = 1.
  - Pulsing i_Rx_Ready clears o_Rx_DV and o_Overrun.
  - A following 0x33 is received normally.
- **Glitches and reset.**
  - A low pulse of H-1 cycles on an idle line: no o_Rx_DV.
  - i_Reset asserted mid-data for 1 cycle: all outputs 0, and the next full frame 0x5A is received correctly.
